decoder_3to8_seq: RTL and testbench

Sequenced 3-to-8 decoder: the transmit-side counterpart of the 8-to-3 encoder in the combinational gates library. It accepts 3-bit codes over a valid/ready handshake and buffers them in a small FIFO. Each code is replayed as a registered one-hot pulse on an 8-bit output, held for a programmable number of cycles and followed by a programmable idle gap. It drives strobe/select lines that an `encoder_8to3` on the far side converts back to codes.

---
 rtl/decoder_pkg.sv | 18 +
 rtl/sync_fifo.sv | 64 ++++++
 rtl/decoder_3to8_seq.sv | 136 +++++++++++++
 tb/tb_decoder_3to8_seq.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared widths, FSM state encoding and the code-to-one-hot helper for the
// sequenced 3-to-8 decoder.
package decoder_pkg;

  localparam int CODE_W = 3;
  localparam int OUT_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    GAP
  } dec_state_t;

  function automatic logic [OUT_W-1:0] onehot(input logic [CODE_W-1:0] code);
    return {{(OUT_W-1){1'b0}}, 1'b1} << code;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through head data, so the
// consumer can use the head in the same cycle it decides to pop.
module sync_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra MSB so that full and empty are distinguishable.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/decoder_3to8_seq.sv
// Sequenced 3-to-8 decoder: queued codes are replayed as registered one-hot
// pulses of HOLD cycles, each followed by GAP idle cycles.
module decoder_3to8_seq #(
  parameter int HOLD  = 4,
  parameter int GAP   = 1,
  parameter int DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [decoder_pkg::CODE_W-1:0]    a,
  input  logic                              a_valid,
  output logic                              a_ready,
  input  logic                              flush,
  output logic [decoder_pkg::OUT_W-1:0]     y,
  output logic                              y_valid,
  output logic                              busy,
  output logic [$clog2(DEPTH):0]            count
);

  import decoder_pkg::*;

  localparam int HOLD_W = $clog2(HOLD + 1);
  localparam int GAP_W  = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  dec_state_t         state_q, state_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [OUT_W-1:0]   y_q, y_d;
  logic               y_valid_q, y_valid_d;

  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CODE_W-1:0]  fifo_head;

  sync_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flush),
    .push_i    (a_valid),
    .wr_data_i (a),
    .pop_i     (fifo_pop),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (count)
  );

  assign a_ready = !fifo_full;
  assign busy    = (state_q != IDLE) || !fifo_empty;
  assign y       = y_q;
  assign y_valid = y_valid_q;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    y_d        = y_q;
    y_valid_d  = y_valid_q;
    fifo_pop   = 1'b0;

    if (flush) begin
      state_d    = IDLE;
      hold_cnt_d = '0;
      gap_cnt_d  = '0;
      y_d        = '0;
      y_valid_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            y_d        = onehot(fifo_head);
            y_valid_d  = 1'b1;
            hold_cnt_d = HOLD_LOAD;
            state_d    = DRIVE;
          end
        end

        DRIVE: begin
          if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - 1'b1;
          end else if (GAP > 0) begin
            y_d       = '0;
            y_valid_d = 1'b0;
            gap_cnt_d = GAP_LOAD;
            state_d   = decoder_pkg::GAP;
          end else if (!fifo_empty) begin
            // No gap configured: chain the next word without a zero cycle.
            fifo_pop   = 1'b1;
            y_d        = onehot(fifo_head);
            y_valid_d  = 1'b1;
            hold_cnt_d = HOLD_LOAD;
          end else begin
            y_d       = '0;
            y_valid_d = 1'b0;
            state_d   = IDLE;
          end
        end

        decoder_pkg::GAP: begin
          if (gap_cnt_q != '0) gap_cnt_d = gap_cnt_q - 1'b1;
          else                 state_d   = IDLE;
        end

        default: begin
          state_d   = IDLE;
          y_d       = '0;
          y_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
      y_q        <= '0;
      y_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      y_q        <= y_d;
      y_valid_q  <= y_valid_d;
    end
  end

endmodule

// File: tb/tb_decoder_3to8_seq.sv
// Directed bench for decoder_3to8_seq: one instance with a gap (HOLD=4, GAP=1)
// and one chaining words back-to-back (HOLD=2, GAP=0).
module tb_decoder_3to8_seq;

  logic       clk;
  logic       rst_n;

  logic [2:0] a_a;
  logic       va_a;
  logic       ready_a;
  logic       flush_a;
  logic [7:0] y_a;
  logic       yv_a;
  logic       busy_a;
  logic [2:0] count_a;

  logic [2:0] a_b;
  logic       va_b;
  logic       ready_b;
  logic       flush_b;
  logic [7:0] y_b;
  logic       yv_b;
  logic       busy_b;
  logic [2:0] count_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] seen_q[$];
  int         len_q[$];
  logic [7:0] prev_y = 8'h00;
  int         run_len = 0;

  decoder_3to8_seq #(.HOLD(4), .GAP(1), .DEPTH(4)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a_a),
    .a_valid (va_a),
    .a_ready (ready_a),
    .flush   (flush_a),
    .y       (y_a),
    .y_valid (yv_a),
    .busy    (busy_a),
    .count   (count_a)
  );

  decoder_3to8_seq #(.HOLD(2), .GAP(0), .DEPTH(4)) u_dut_b2b (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a_b),
    .a_valid (va_b),
    .a_ready (ready_b),
    .flush   (flush_b),
    .y       (y_b),
    .y_valid (yv_b),
    .busy    (busy_b),
    .count   (count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (observed running, expected done)");
    $fatal(1, "watchdog expired");
  end

  // Records every distinct word on instance A with the number of cycles it stayed up.
  always @(posedge clk) begin
    #1;
    n_cmp++;
    assert (yv_a === (y_a != 8'h00)) else begin
      n_err++;
      $error("FAIL yvalid_track: observed y_valid=%0b with y=%02h, expected y_valid=%0b",
             yv_a, y_a, (y_a != 8'h00));
    end
    if (y_a !== prev_y) begin
      if (prev_y != 8'h00) len_q.push_back(run_len);
      if (y_a != 8'h00) seen_q.push_back(y_a);
      run_len = 1;
    end else begin
      run_len++;
    end
    prev_y = y_a;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %02h, expected %02h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [2:0] code);
    int g;
    a_a  = code;
    va_a = 1'b1;
    g    = 0;
    while (ready_a !== 1'b1 && g < 100) begin
      tick();
      g++;
    end
    n_cmp++;
    assert (g < 100) else begin
      n_err++;
      $error("FAIL push_timeout: observed a_ready low for %0d cycles, expected < 100", g);
    end
    tick();
    $display("push code %0d after %0d stall cycles", code, g);
  endtask

  task automatic wait_idle_a(input string tag);
    int g;
    g = 0;
    while (busy_a !== 1'b0 && g < 300) begin
      tick();
      g++;
    end
    n_cmp++;
    assert (g < 300) else begin
      n_err++;
      $error("FAIL %s: observed busy for %0d cycles, expected idle within 300", tag, g);
    end
  endtask

  initial begin
    logic [7:0] sweep_exp [8];
    logic [7:0] bp_exp [6];
    sweep_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    bp_exp    = '{8'h80, 8'h04, 8'h20, 8'h01, 8'h08, 8'h40};

    rst_n = 1'b0;
    a_a = 3'd0; va_a = 1'b0; flush_a = 1'b0;
    a_b = 3'd0; va_b = 1'b0; flush_b = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_y", y_a, 8'h00);
    chk("rst_yv", {7'd0, yv_a}, 8'h00);
    chk("rst_count", {5'd0, count_a}, 8'h00);
    chk("rst_busy", {7'd0, busy_a}, 8'h00);
    chk("rst_ready", {7'd0, ready_a}, 8'h01);
    rst_n = 1'b1;
    tick();

    // Single code 5: one cycle latency, 4 cycles high, 1 gap cycle, then idle
    a_a = 3'd5; va_a = 1'b1;
    tick();
    va_a = 1'b0;
    $display("single: pushed code 5");
    chk("single_count", {5'd0, count_a}, 8'h01);
    chk("single_y_lat0", y_a, 8'h00);
    chk("single_busy0", {7'd0, busy_a}, 8'h01);
    tick();
    chk("single_y_c0", y_a, 8'h20);
    chk("single_yv_c0", {7'd0, yv_a}, 8'h01);
    chk("single_count_pop", {5'd0, count_a}, 8'h00);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("single_y_hold", y_a, 8'h20);
    end
    tick();
    chk("single_y_gap", y_a, 8'h00);
    chk("single_busy_gap", {7'd0, busy_a}, 8'h01);
    tick();
    chk("single_busy_end", {7'd0, busy_a}, 8'h00);

    // Full sweep 0..7 with a_valid held high
    seen_q.delete();
    len_q.delete();
    for (int c = 0; c < 8; c++) push_a(3'(c));
    va_a = 1'b0;
    wait_idle_a("sweep_idle");
    chk("sweep_n", 8'(seen_q.size()), 8'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("sweep_word%0d", i), seen_q[i], sweep_exp[i]);
      chk($sformatf("sweep_ones%0d", i), 8'($countones(seen_q[i])), 8'd1);
      chk($sformatf("sweep_len%0d", i), 8'(len_q[i]), 8'd4);
    end

    // Backpressure: six codes into a four-entry FIFO
    seen_q.delete();
    len_q.delete();
    va_a = 1'b1;
    a_a = 3'd7; tick();
    a_a = 3'd2; tick();
    a_a = 3'd5; tick();
    a_a = 3'd0; tick();
    a_a = 3'd3; tick();
    chk("bp_count_full", {5'd0, count_a}, 8'h04);
    chk("bp_ready_full", {7'd0, ready_a}, 8'h00);
    a_a = 3'd6;
    tick();
    chk("bp_ready_stall1", {7'd0, ready_a}, 8'h00);
    chk("bp_count_stall1", {5'd0, count_a}, 8'h04);
    tick();
    chk("bp_ready_stall2", {7'd0, ready_a}, 8'h00);
    tick();
    chk("bp_count_afterpop", {5'd0, count_a}, 8'h03);
    chk("bp_ready_afterpop", {7'd0, ready_a}, 8'h01);
    tick();
    va_a = 1'b0;
    chk("bp_count_last", {5'd0, count_a}, 8'h04);
    wait_idle_a("bp_idle");
    chk("bp_n", 8'(seen_q.size()), 8'd6);
    for (int i = 0; i < 6; i++) chk($sformatf("bp_word%0d", i), seen_q[i], bp_exp[i]);

    // Flush with three queued and code 1 on the output; concurrent write dropped
    va_a = 1'b1;
    a_a = 3'd1; tick();
    a_a = 3'd4; tick();
    a_a = 3'd6; tick();
    a_a = 3'd2; tick();
    chk("flush_pre_y", y_a, 8'h02);
    chk("flush_pre_count", {5'd0, count_a}, 8'h03);
    a_a = 3'd7;
    flush_a = 1'b1;
    tick();
    flush_a = 1'b0;
    va_a = 1'b0;
    $display("flush applied with code 7 presented");
    chk("flush_y", y_a, 8'h00);
    chk("flush_yv", {7'd0, yv_a}, 8'h00);
    chk("flush_count", {5'd0, count_a}, 8'h00);
    chk("flush_busy", {7'd0, busy_a}, 8'h00);
    chk("flush_ready", {7'd0, ready_a}, 8'h01);
    tick();
    tick();
    chk("flush_after_y", y_a, 8'h00);
    chk("flush_after_count", {5'd0, count_a}, 8'h00);

    // Back-to-back on the GAP=0, HOLD=2 instance: codes 3 then 6
    va_b = 1'b1;
    a_b = 3'd3; tick();
    a_b = 3'd6; tick();
    va_b = 1'b0;
    $display("b2b: pushed codes 3 and 6");
    chk("b2b_y0", y_b, 8'h08);
    tick();
    chk("b2b_y1", y_b, 8'h08);
    tick();
    chk("b2b_y2", y_b, 8'h40);
    chk("b2b_yv2", {7'd0, yv_b}, 8'h01);
    tick();
    chk("b2b_y3", y_b, 8'h40);
    tick();
    chk("b2b_y4", y_b, 8'h00);
    chk("b2b_busy4", {7'd0, busy_b}, 8'h00);

    // Asynchronous reset in the middle of a pulse
    va_a = 1'b1;
    a_a = 3'd5; tick();
    a_a = 3'd2; tick();
    va_a = 1'b0;
    chk("arst_pre_y", y_a, 8'h20);
    chk("arst_pre_count", {5'd0, count_a}, 8'h01);
    #3;
    rst_n = 1'b0;
    #1;
    $display("async reset asserted mid-pulse");
    chk("arst_y", y_a, 8'h00);
    chk("arst_yv", {7'd0, yv_a}, 8'h00);
    chk("arst_count", {5'd0, count_a}, 8'h00);
    chk("arst_busy", {7'd0, busy_a}, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_rel_ready", {7'd0, ready_a}, 8'h01);
    chk("arst_rel_y", y_a, 8'h00);
    chk("arst_rel_busy", {7'd0, busy_a}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
